pong_match_scheduler: RTL and testbench

//  Pairs up to 4 player nodes into 2 game slots and sequences each slot's rally engine.
//  Per slot: serve countdown, play enable, score keeping from miss events, game-over hold.

---
 rtl/pong_match_scheduler_pkg.sv | 27 ++
 rtl/pong_match_scheduler_if.sv | 34 +++
 rtl/pong_match_scheduler_slot_fsm.sv | 135 +++++++++++++
 rtl/pong_match_scheduler.sv | 135 +++++++++++++
 tb/tb_pong_match_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_match_scheduler_pkg.sv
// Shared types and constants for the pong match scheduler and the game server.
package pong_match_scheduler_pkg;

  localparam int NUM_NODES   = 4;
  localparam int NUM_SLOTS   = 2;
  localparam int SCORE_W     = 4;
  localparam int WIN_SCORE   = 7;
  localparam int SERVE_TICKS = 32;
  localparam int OVER_TICKS  = 64;
  localparam int CNT_W       = 7;

  // Playfield geometry used by the game server when routing paddle y values.
  localparam int FIELD_W    = 160;
  localparam int FIELD_H    = 120;
  localparam int BORDER_TOP = 0;
  localparam int BORDER_BOT = FIELD_H - 1;
  localparam int PADDLE_X_L = 4;
  localparam int PADDLE_X_R = FIELD_W - 5;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} slot_state_t;
  typedef enum logic [1:0] {FREE, WAIT, PLAYING} node_state_t;

  typedef logic [1:0]         node_id_t;
  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/pong_match_scheduler_if.sv
// Node link-layer and ball-engine signals of the match scheduler.
interface pong_match_scheduler_if;
  import pong_match_scheduler_pkg::*;

  logic [NUM_NODES-1:0]           join_req;
  logic [NUM_NODES-1:0]           leave_req;
  logic [NUM_NODES-1:0]           join_ack;
  logic [NUM_NODES-1:0]           node_busy;
  logic [NUM_SLOTS-1:0]           miss_left;
  logic [NUM_SLOTS-1:0]           miss_right;
  logic [NUM_SLOTS-1:0]           slot_active;
  node_id_t [NUM_SLOTS-1:0]       slot_p1;
  node_id_t [NUM_SLOTS-1:0]       slot_p2;
  logic [NUM_SLOTS-1:0]           ball_run;
  logic [NUM_SLOTS-1:0]           ball_serve;
  logic [NUM_SLOTS-1:0]           serve_dir;
  score_t [NUM_SLOTS-1:0]         score_p1;
  score_t [NUM_SLOTS-1:0]         score_p2;
  logic [NUM_SLOTS-1:0]           game_over;
  logic [NUM_SLOTS-1:0]           winner;

  modport master (
    output join_req, leave_req, miss_left, miss_right,
    input  join_ack, node_busy, slot_active, slot_p1, slot_p2, ball_run,
    input  ball_serve, serve_dir, score_p1, score_p2, game_over, winner
  );

  modport slave (
    input  join_req, leave_req, miss_left, miss_right,
    output join_ack, node_busy, slot_active, slot_p1, slot_p2, ball_run,
    output ball_serve, serve_dir, score_p1, score_p2, game_over, winner
  );

endinterface

// File: rtl/pong_match_scheduler_slot_fsm.sv
// One game slot: serve countdown, rally enable, scoring and game-over hold.
module pong_match_scheduler_slot_fsm
  import pong_match_scheduler_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 start,
  input  node_id_t             start_p1,
  input  node_id_t             start_p2,
  input  logic [NUM_NODES-1:0] leave_req,
  input  logic                 miss_left,
  input  logic                 miss_right,
  output logic                 idle,
  output logic                 release_now,
  output logic                 active,
  output node_id_t             p1,
  output node_id_t             p2,
  output logic                 ball_run,
  output logic                 ball_serve,
  output logic                 serve_dir,
  output score_t               score_p1,
  output score_t               score_p2,
  output logic                 game_over,
  output logic                 winner
);

  slot_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  score_t      sc1_q, sc1_d, sc2_q, sc2_d;
  logic        dir_q, dir_d, win_q, win_d;
  node_id_t    p1_q, p1_d, p2_q, p2_d;
  logic        abort, expire;

  // A leave from either seated player overrides everything else in the slot.
  assign abort  = (state_q != IDLE) && (leave_req[p1_q] || leave_req[p2_q]);
  assign expire = tick && (cnt_q == cnt_t'(1));

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sc1_q   <= '0;
      sc2_q   <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc1_d   = sc1_q;
    sc2_d   = sc2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    if (abort) begin
      state_d = IDLE;
      sc1_d   = '0;
      sc2_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = SERVE;
          cnt_d   = cnt_t'(SERVE_TICKS);
          sc1_d   = '0;
          sc2_d   = '0;
          dir_d   = 1'b0;
          p1_d    = start_p1;
          p2_d    = start_p2;
        end
        SERVE: if (tick) begin
          if (expire) state_d = PLAY;
          else        cnt_d   = cnt_q - cnt_t'(1);
        end
        PLAY: if (miss_left || miss_right) begin
          // miss_left takes precedence; the point goes against the left player.
          if (miss_left) sc2_d = sc2_q + score_t'(1);
          else           sc1_d = sc1_q + score_t'(1);
          if ((sc1_d == score_t'(WIN_SCORE)) || (sc2_d == score_t'(WIN_SCORE))) begin
            state_d = OVER;
            win_d   = miss_left;
            cnt_d   = cnt_t'(OVER_TICKS);
          end else begin
            state_d = SERVE;
            dir_d   = !miss_left;
            cnt_d   = cnt_t'(SERVE_TICKS);
          end
        end
        OVER: if (tick) begin
          if (expire) begin
            state_d = IDLE;
            sc1_d   = '0;
            sc2_d   = '0;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Slot outputs; ball_serve fires on the expiring tick itself.
  always_comb begin
    idle        = (state_q == IDLE);
    active      = (state_q != IDLE);
    ball_run    = (state_q == PLAY);
    game_over   = (state_q == OVER);
    ball_serve  = (state_q == SERVE) && expire && !abort;
    release_now = abort || ((state_q == OVER) && expire);
    p1          = p1_q;
    p2          = p2_q;
    serve_dir   = dir_q;
    winner      = win_q;
    score_p1    = sc1_q;
    score_p2    = sc2_q;
  end

endmodule

// File: rtl/pong_match_scheduler.sv
// Node pool, round-robin pairing into game slots, and slot release fan-out.
module pong_match_scheduler
  import pong_match_scheduler_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   tick,
  pong_match_scheduler_if.slave  bus
);

  node_state_t              node_q [NUM_NODES];
  logic [NUM_NODES-1:0]     ack_q, wait_ok, paired, freed, busy;
  node_id_t                 rr_q, pair_p1, pair_p2, idx;
  logic                     first_found, pair_found, taken;
  logic [NUM_SLOTS-1:0]     slot_idle, slot_rel, slot_start;
  logic [NUM_SLOTS-1:0]     s_active, s_run, s_serve, s_dir, s_over, s_win;
  node_id_t [NUM_SLOTS-1:0] sp1, sp2;
  score_t [NUM_SLOTS-1:0]   ssc1, ssc2;

  // Pair search from rr_q, slot pick and release fan-out; a leaving node is never paired.
  always_comb begin
    wait_ok     = '0;
    paired      = '0;
    freed       = '0;
    slot_start  = '0;
    first_found = 1'b0;
    pair_found  = 1'b0;
    taken       = 1'b0;
    pair_p1     = rr_q;
    pair_p2     = rr_q;
    idx         = rr_q;
    for (int n = 0; n < NUM_NODES; n++)
      wait_ok[n] = (node_q[n] == WAIT) && !bus.leave_req[n];
    for (int i = 0; i < NUM_NODES; i++) begin
      idx = rr_q + node_id_t'(i);
      if (wait_ok[idx]) begin
        if (!first_found) begin
          pair_p1     = idx;
          first_found = 1'b1;
        end else if (!pair_found) begin
          pair_p2    = idx;
          pair_found = 1'b1;
        end
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (pair_found && slot_idle[s] && !taken) begin
        slot_start[s] = 1'b1;
        taken         = 1'b1;
      end
    end
    if (taken) begin
      paired[pair_p1] = 1'b1;
      paired[pair_p2] = 1'b1;
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_rel[s]) begin
        freed[sp1[s]] = 1'b1;
        freed[sp2[s]] = 1'b1;
      end
    end
  end

  // Node lifecycle, join acknowledge and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_NODES; n++) node_q[n] <= FREE;
      ack_q <= '0;
      rr_q  <= '0;
    end else begin
      ack_q <= '0;
      for (int n = 0; n < NUM_NODES; n++) begin
        case (node_q[n])
          FREE: if (bus.join_req[n] && !bus.leave_req[n]) begin
            node_q[n] <= WAIT;
            ack_q[n]  <= 1'b1;
          end
          WAIT: begin
            if (bus.leave_req[n]) node_q[n] <= FREE;
            else if (paired[n])   node_q[n] <= PLAYING;
          end
          PLAYING: if (freed[n]) node_q[n] <= FREE;
          default: node_q[n] <= FREE;
        endcase
      end
      if (taken) rr_q <= pair_p2 + node_id_t'(1);
    end
  end

  // Busy flag per node.
  always_comb begin
    busy = '0;
    for (int n = 0; n < NUM_NODES; n++) busy[n] = (node_q[n] != FREE);
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    pong_match_scheduler_slot_fsm u_slot (
      .clock       (clock),
      .reset_n     (reset_n),
      .tick        (tick),
      .start       (slot_start[s]),
      .start_p1    (pair_p1),
      .start_p2    (pair_p2),
      .leave_req   (bus.leave_req),
      .miss_left   (bus.miss_left[s]),
      .miss_right  (bus.miss_right[s]),
      .idle        (slot_idle[s]),
      .release_now (slot_rel[s]),
      .active      (s_active[s]),
      .p1          (sp1[s]),
      .p2          (sp2[s]),
      .ball_run    (s_run[s]),
      .ball_serve  (s_serve[s]),
      .serve_dir   (s_dir[s]),
      .score_p1    (ssc1[s]),
      .score_p2    (ssc2[s]),
      .game_over   (s_over[s]),
      .winner      (s_win[s])
    );
  end

  assign bus.join_ack    = ack_q;
  assign bus.node_busy   = busy;
  assign bus.slot_active = s_active;
  assign bus.slot_p1     = sp1;
  assign bus.slot_p2     = sp2;
  assign bus.ball_run    = s_run;
  assign bus.ball_serve  = s_serve;
  assign bus.serve_dir   = s_dir;
  assign bus.score_p1    = ssc1;
  assign bus.score_p2    = ssc2;
  assign bus.game_over   = s_over;
  assign bus.winner      = s_win;

endmodule

// File: tb/tb_pong_match_scheduler.sv
// Bench for pong_match_scheduler: directed scenarios plus random traffic against a game-level model.
module tb_pong_match_scheduler;
  import pong_match_scheduler_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;

  pong_match_scheduler_if bus ();

  pong_match_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: node 0=free 1=waiting 2=playing; slot 0=idle 1=serving 2=rally 3=over.
  int m_nst [4];
  bit m_ack [4];
  int m_sst [2];
  int m_cnt [2];
  int m_sc1 [2];
  int m_sc2 [2];
  int m_dir [2];
  int m_win [2];
  int m_p1  [2];
  int m_p2  [2];
  int m_rr;
  logic [1:0] obs_bs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin m_nst[n] = 0; m_ack[n] = 0; end
    for (int s = 0; s < 2; s++) begin
      m_sst[s] = 0; m_cnt[s] = 0; m_sc1[s] = 0; m_sc2[s] = 0;
      m_dir[s] = 0; m_win[s] = 0; m_p1[s] = 0; m_p2[s] = 0;
    end
    m_rr = 0;
  endtask

  function automatic bit leaving(input logic [3:0] lr, input int s);
    return (m_sst[s] != 0) && (lr[m_p1[s]] || lr[m_p2[s]]);
  endfunction

  task automatic compare(input logic tk, input logic [3:0] lr);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("join_ack[%0d]", n), int'(bus.join_ack[n]), int'(m_ack[n]));
      chk($sformatf("node_busy[%0d]", n), int'(bus.node_busy[n]), int'(m_nst[n] != 0));
    end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("slot_active[%0d]", s), int'(bus.slot_active[s]), int'(m_sst[s] != 0));
      chk($sformatf("ball_run[%0d]", s), int'(bus.ball_run[s]), int'(m_sst[s] == 2));
      chk($sformatf("game_over[%0d]", s), int'(bus.game_over[s]), int'(m_sst[s] == 3));
      chk($sformatf("slot_p1[%0d]", s), int'(bus.slot_p1[s]), m_p1[s]);
      chk($sformatf("slot_p2[%0d]", s), int'(bus.slot_p2[s]), m_p2[s]);
      chk($sformatf("score_p1[%0d]", s), int'(bus.score_p1[s]), m_sc1[s]);
      chk($sformatf("score_p2[%0d]", s), int'(bus.score_p2[s]), m_sc2[s]);
      chk($sformatf("ball_serve[%0d]", s), int'(bus.ball_serve[s]),
          int'(m_sst[s] == 1 && tk && m_cnt[s] == 1 && !leaving(lr, s)));
      if (m_sst[s] != 0)
        chk($sformatf("serve_dir[%0d]", s), int'(bus.serve_dir[s]), m_dir[s]);
      if (m_sst[s] == 3)
        chk($sformatf("winner[%0d]", s), int'(bus.winner[s]), m_win[s]);
    end
  endtask

  task automatic model_step(input logic [3:0] jr, input logic [3:0] lr,
                            input logic [1:0] ml, input logic [1:0] mr, input logic tk);
    bit idle_now [2];
    bit rel [2];
    int wl [$];
    int slot;
    for (int s = 0; s < 2; s++) begin idle_now[s] = (m_sst[s] == 0); rel[s] = 0; end
    for (int k = 0; k < 4; k++) begin
      int n = (m_rr + k) % 4;
      if (m_nst[n] == 1 && !lr[n]) wl.push_back(n);
    end
    for (int s = 0; s < 2; s++) begin
      if (leaving(lr, s)) begin
        m_sst[s] = 0; m_sc1[s] = 0; m_sc2[s] = 0; rel[s] = 1;
      end else if (m_sst[s] == 1 && tk) begin
        if (m_cnt[s] == 1) m_sst[s] = 2; else m_cnt[s]--;
      end else if (m_sst[s] == 2 && (ml[s] || mr[s])) begin
        if (ml[s]) m_sc2[s]++; else m_sc1[s]++;
        if (m_sc1[s] == WIN_SCORE || m_sc2[s] == WIN_SCORE) begin
          m_sst[s] = 3; m_win[s] = ml[s] ? 1 : 0; m_cnt[s] = OVER_TICKS;
        end else begin
          m_sst[s] = 1; m_dir[s] = ml[s] ? 0 : 1; m_cnt[s] = SERVE_TICKS;
        end
      end else if (m_sst[s] == 3 && tk) begin
        if (m_cnt[s] == 1) begin
          m_sst[s] = 0; m_sc1[s] = 0; m_sc2[s] = 0; rel[s] = 1;
        end else m_cnt[s]--;
      end
    end
    for (int n = 0; n < 4; n++) begin
      m_ack[n] = 0;
      if (m_nst[n] == 0 && jr[n] && !lr[n]) begin m_nst[n] = 1; m_ack[n] = 1; end
      else if (m_nst[n] == 1 && lr[n]) m_nst[n] = 0;
    end
    for (int s = 0; s < 2; s++)
      if (rel[s]) begin m_nst[m_p1[s]] = 0; m_nst[m_p2[s]] = 0; end
    slot = -1;
    if (wl.size() >= 2) begin
      if (idle_now[0]) slot = 0;
      else if (idle_now[1]) slot = 1;
    end
    if (slot >= 0) begin
      m_sst[slot] = 1; m_cnt[slot] = SERVE_TICKS; m_sc1[slot] = 0; m_sc2[slot] = 0;
      m_dir[slot] = 0; m_p1[slot] = wl[0]; m_p2[slot] = wl[1];
      m_nst[wl[0]] = 2; m_nst[wl[1]] = 2;
      m_rr = (wl[1] + 1) % 4;
    end
  endtask

  // One clock: drive at the falling edge, check, advance the model, clear pulses after the edge.
  task automatic step(input logic [3:0] jr, input logic [3:0] lr,
                      input logic [1:0] ml, input logic [1:0] mr, input logic tk);
    bus.join_req = jr; bus.leave_req = lr; bus.miss_left = ml; bus.miss_right = mr; tick = tk;
    #1;
    compare(tk, lr);
    obs_bs = bus.ball_serve;
    model_step(jr, lr, ml, mr, tk);
    @(posedge clock);
    #1;
    bus.join_req = '0; bus.leave_req = '0; bus.miss_left = '0; bus.miss_right = '0; tick = 1'b0;
    @(negedge clock);
  endtask

  task automatic serve_wait(input int s);
    int n = 0;
    bit got = 0;
    while (!got && n < 300) begin
      step(4'b0, 4'b0, 2'b0, 2'b0, 1'b1);
      n++;
      got = obs_bs[s];
    end
    chk($sformatf("serve_wait[%0d]", s), int'(got), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.join_req = '0; bus.leave_req = '0; bus.miss_left = '0; bus.miss_right = '0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_slot_active", int'(bus.slot_active), 0);
    chk("rst_node_busy", int'(bus.node_busy), 0);
    chk("rst_ball_run", int'(bus.ball_run), 0);
    chk("rst_scores", int'({bus.score_p1, bus.score_p2}), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Node0 joins, node2 three clocks later, then serve after 32 ticks.
    step(4'b0001, 0, 0, 0, 0);
    chk("t1_ack0", int'(bus.join_ack[0]), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    chk("t1_ack2", int'(bus.join_ack[2]), 1);
    step(0, 0, 0, 0, 0);
    chk("t1_active", int'(bus.slot_active[0]), 1);
    chk("t1_p1", int'(bus.slot_p1[0]), 0);
    chk("t1_p2", int'(bus.slot_p2[0]), 2);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step(0, 0, 0, 0, 1'(i % 2));
      if (i % 2 == 1) cnt++;
      if (obs_bs[0]) break;
    end
    chk("t1_serve_ticks", cnt, 32);
    chk("t1_run", int'(bus.ball_run[0]), 1);

    // Seven right-side misses win the game for p1, then the 64-tick hold.
    for (int p = 1; p <= 7; p++) begin
      step(0, 0, 2'b00, 2'b01, 0);
      if (p < 7) begin
        chk("t2_score", int'(bus.score_p1[0]), p);
        serve_wait(0);
      end
    end
    chk("t2_final", int'(bus.score_p1[0]), 7);
    chk("t2_over", int'(bus.game_over[0]), 1);
    chk("t2_winner", int'(bus.winner[0]), 0);
    repeat (63) step(0, 0, 0, 0, 1);
    chk("t2_hold", int'(bus.game_over[0]), 1);
    step(0, 0, 0, 0, 1);
    chk("t2_idle", int'(bus.slot_active[0]), 0);
    chk("t2_free", int'({bus.node_busy[2], bus.node_busy[0]}), 0);
    chk("t2_clear", int'(bus.score_p1[0]), 0);

    // All four join together from a fresh reset.
    do_reset();
    step(4'b1111, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_s0", int'({bus.slot_active, bus.slot_p1[0], bus.slot_p2[0]}), 'b01_00_01);
    step(0, 0, 0, 0, 0);
    chk("t3_s1", int'({bus.slot_active, bus.slot_p1[1], bus.slot_p2[1]}), 'b11_10_11);

    // Simultaneous misses: only the left miss counts.
    serve_wait(0);
    step(0, 0, 2'b01, 2'b01, 0);
    chk("t4_p2", int'(bus.score_p2[0]), 1);
    chk("t4_p1", int'(bus.score_p1[0]), 0);
    chk("t4_dir", int'(bus.serve_dir[0]), 0);

    // Slot1 to 3-2, then node2 leaves mid-rally.
    for (int p = 0; p < 5; p++) begin
      if (p > 0) serve_wait(1);
      step(0, 0, (p >= 3) ? 2'b10 : 2'b00, (p < 3) ? 2'b10 : 2'b00, 0);
    end
    serve_wait(1);
    chk("t5_score", int'({bus.score_p1[1], bus.score_p2[1]}), 'h32);
    step(0, 4'b0100, 0, 0, 0);
    chk("t5_idle", int'(bus.slot_active[1]), 0);
    chk("t5_clear", int'({bus.score_p1[1], bus.score_p2[1]}), 0);
    chk("t5_no_over", int'(bus.game_over[1]), 0);
    chk("t5_free", int'({bus.node_busy[3], bus.node_busy[2]}), 0);
    step(0, 0, 0, 0, 0);
    chk("t5_still_free", int'(bus.node_busy[3]), 0);
    step(4'b1100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_repair", int'({bus.slot_p1[1], bus.slot_p2[1]}), 'b10_11);

    // Reset during a serve countdown.
    repeat (5) step(0, 0, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_active", int'(bus.slot_active), 0);
    chk("t6_busy", int'(bus.node_busy), 0);
    chk("t6_run", int'(bus.ball_run | bus.ball_serve | bus.game_over), 0);
    chk("t6_p", int'({bus.slot_p1, bus.slot_p2}), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0, 1);
      if (obs_bs != 2'b00) cnt++;
    end
    chk("t6_no_serve", cnt, 0);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      logic [3:0] jr, lr;
      logic [1:0] ml, mr;
      for (int n = 0; n < 4; n++) begin
        jr[n] = ($urandom_range(0, 3) == 0);
        lr[n] = ($urandom_range(0, 199) == 0);
      end
      for (int s = 0; s < 2; s++) begin
        ml[s] = ($urandom_range(0, 5) == 0);
        mr[s] = ($urandom_range(0, 5) == 0);
      end
      step(jr, lr, ml, mr, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
